prog_mem_loader: RTL and testbench
==================================

Name: prog_mem_loader

Overview:
- Program-memory responder on the instruction-fetch interface: receives the 11-bit PC from the control unit and returns the 16-bit instruction word.
- Also contains a byte-stream loader FSM. It writes a new program into the memory while holding the CPU in reset, then releases the CPU to run from address 0.
- Sits between the control unit's fetch port and a byte source (UART receiver or testbench).

Parameters:
ADDR_W, 11, PC / memory address width
DATA_W, 16, instruction width (5-bit opcode + 11-bit operand)
DEPTH, 2048, number of instruction words (2**ADDR_W)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clock is clock
pc  input  11  fetch address from control unit
instruction  output  16  registered instruction word, mem[pc] one cycle after pc is sampled
load_start  input  1  single-cycle request to begin a program load
byte_data  input  8  loader byte
byte_valid  input  1  byte_data valid
byte_ready  output  1  loader can accept a byte this cycle
cpu_reset  output  1  registered, holds the CPU in reset during a load
load_done  output  1  one-cycle pulse when a load completes successfully
load_err  output  1  sticky; set on an oversized length, cleared by the next accepted load_start or by reset
word_count  output  12  number of words written by the current or last load

Behaviour:
- Reset values:
  - state=RUN
  - instruction=16'h0000, the HLT encoding
  - byte_ready=0, cpu_reset=0, load_done=0, load_err=0, word_count=0
  - memory contents are not cleared
- States: RUN, LEN_HI, LEN_LO, W_HI, W_LO, DONE.
- Byte handshake: a byte transfers on a rising edge where byte_valid && byte_ready.
  - byte_ready is a registered function of state: 1 in LEN_HI, LEN_LO, W_HI, W_LO; 0 otherwise.
  - byte_valid with byte_ready=0 is ignored; the byte is not queued.
- RUN:
  - instruction <= mem[pc] every edge, so read latency is 1 cycle.
  - load_start=1 -> LEN_HI, load_err<=0, word_count<=0, wr_addr<=0.
- All non-RUN states:
  - instruction <= 16'h0000.
  - cpu_reset<=1, asserted on the same edge the FSM leaves RUN.
  - load_start is ignored.
- LEN_HI: on transfer, len[15:8]<=byte -> LEN_LO.
- LEN_LO: on transfer, len[7:0]<=byte, then:
  - if {len_hi,byte}==0 -> DONE; no memory writes occur.
  - else if the value is >DEPTH -> load_err<=1 -> RUN; memory is unchanged and no load_done pulse is issued.
  - else -> W_HI.
- W_HI: on transfer, hold byte as word[15:8] -> W_LO. This is big-endian: the opcode byte comes first.
- W_LO: on transfer, mem[wr_addr] <= {hi,byte}, wr_addr++, word_count++.
  - if word_count+1==len -> DONE, else -> W_HI.
- DONE: load_done=1 for this cycle, cpu_reset stays 1, next state RUN.
  - On the RUN entry edge cpu_reset<=0 and instruction <= mem[pc].
  - The CPU has been in reset, so pc=0 and the first fetch is mem[0].
- Length arithmetic:
  - len is 16 bits; the comparison against DEPTH uses the full width.
  - wr_addr is ADDR_W bits; with len<=DEPTH it never wraps.
- Reset mid-load: the FSM returns to RUN with cpu_reset=0.
  - Partially written words remain in memory; the rest are untouched.
  - No load_done pulse is issued.
- Simultaneous load_start and byte_valid in RUN: the byte is dropped, since byte_ready=0 that cycle.
- The memory is single-port. Writes occur only in W_LO and reads only in RUN, so no read/write collision exists.

Test Plan:
- Reset check: assert reset, release -> instruction=0, cpu_reset=0, byte_ready=0, load_done=0, load_err=0, word_count=0.
- Normal load: load_start, then bytes 00 03 | 08 05 | 10 06 | 00 00 -> mem[0..2]=16'h0805,16'h1006,16'h0000. load_done pulses once, word_count=3, cpu_reset falls the cycle after DONE. Then pc=0,1,2 -> instruction 0805,1006,0000 each 1 cycle after pc.
- Backpressure and gaps: the same stream with byte_valid low for 1–3 random cycles between bytes -> identical memory contents and word_count=3; bytes presented while byte_ready=0 are not consumed.
- Boundary lengths:
  - len=0 (00 00) -> load_done pulses, memory unchanged, word_count=0.
  - len=2048 (08 00) with 4096 data bytes -> mem[2047] written, load_done pulses.
  - len=2049 (08 01) -> load_err=1, FSM back in RUN, cpu_reset=0, no load_done, memory unchanged.
- Reset mid-load: after 1.5 words of a 3-word load, pulse reset -> state RUN, byte_ready=0, cpu_reset=0, mem[0] holds word 1, mem[1] unchanged; a following full load succeeds.
- load_start during load: pulse load_start while in W_HI -> ignored; the load completes normally with the original length.

Source files
------------

// File: rtl/prog_mem_loader.sv
// prog_mem_loader
//   Instruction memory for the CPU fetch port, plus a byte-stream loader.
//   The loader writes a new program while holding the CPU in reset, then
//   releases the CPU so it runs from address 0.
//
//   Load stream (big-endian): LEN[15:8] LEN[7:0] then LEN words, each sent
//   as the opcode byte first and the operand byte second.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-high
//   pc           fetch address from the control unit
//   instruction  registered mem[pc], one cycle after pc is sampled
//   load_start   single-cycle request to begin a program load (RUN only)
//   byte_data    loader byte
//   byte_valid   byte_data valid
//   byte_ready   loader accepts a byte this cycle
//   cpu_reset    holds the CPU in reset while a load is in progress
//   load_done    one-cycle pulse when a load completes
//   load_err     sticky oversize-length flag, cleared by load_start or reset
//   word_count   words written by the current or last load
module prog_mem_loader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2048
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instruction,
    input  logic              load_start,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        RUN,
        LEN_HI,
        LEN_LO,
        W_HI,
        W_LO,
        DONE
    } state_t;

    // 17 bits so the comparison covers the full 16-bit length.
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [DATA_W-1:0] instruction_q;
    logic              byte_ready_q;
    logic              cpu_reset_q;
    logic              load_done_q;
    logic              load_err_q, load_err_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        hi_q, hi_d;

    logic              xfer;
    logic              we;
    logic [15:0]       len_full;
    logic [15:0]       wc_plus1;

    assign xfer     = byte_valid && byte_ready_q;
    assign len_full = {len_q[15:8], byte_data};
    assign wc_plus1 = 16'(word_count_q) + 16'd1;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        hi_d         = hi_q;
        wr_addr_d    = wr_addr_q;
        word_count_d = word_count_q;
        load_err_d   = load_err_q;
        we           = 1'b0;
        case (state_q)
            RUN: begin
                if (load_start) begin
                    state_d      = LEN_HI;
                    load_err_d   = 1'b0;
                    word_count_d = '0;
                    wr_addr_d    = '0;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = byte_data;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = byte_data;
                    if (len_full == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, len_full} > DEPTH_L) begin
                        load_err_d = 1'b1;
                        state_d    = RUN;
                    end else begin
                        state_d = W_HI;
                    end
                end
            end
            W_HI: begin
                if (xfer) begin
                    hi_d    = byte_data;
                    state_d = W_LO;
                end
            end
            W_LO: begin
                if (xfer) begin
                    we           = 1'b1;
                    wr_addr_d    = wr_addr_q + 1'b1;
                    word_count_d = word_count_q + 1'b1;
                    state_d      = (wc_plus1 == len_q) ? DONE : W_HI;
                end
            end
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Registered outputs are derived from the next state so that they
    // change on the same edge as the state itself.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            instruction_q <= '0;
            byte_ready_q  <= 1'b0;
            cpu_reset_q   <= 1'b0;
            load_done_q   <= 1'b0;
            load_err_q    <= 1'b0;
            word_count_q  <= '0;
            wr_addr_q     <= '0;
            len_q         <= '0;
            hi_q          <= '0;
        end else begin
            state_q       <= state_d;
            instruction_q <= (state_d == RUN) ? mem[pc] : '0;
            byte_ready_q  <= (state_d == LEN_HI) || (state_d == LEN_LO) ||
                             (state_d == W_HI)   || (state_d == W_LO);
            cpu_reset_q   <= (state_d != RUN);
            load_done_q   <= (state_d == DONE);
            load_err_q    <= load_err_d;
            word_count_q  <= word_count_d;
            wr_addr_q     <= wr_addr_d;
            len_q         <= len_d;
            hi_q          <= hi_d;
        end
    end

    // Program storage is never cleared, so it lives outside the reset domain.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr_q] <= {hi_q, byte_data};
        end
    end

    assign instruction = instruction_q;
    assign byte_ready  = byte_ready_q;
    assign cpu_reset   = cpu_reset_q;
    assign load_done   = load_done_q;
    assign load_err    = load_err_q;
    assign word_count  = word_count_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
module tb_prog_mem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] pc = '0;
    logic [15:0] instruction;
    logic        load_start = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;
    logic [11:0] word_count;

    int nchk = 0;
    int nfail = 0;
    int done_cnt = 0;

    logic [15:0] ref_mem [2048];
    logic [7:0]  tx [$];

    prog_mem_loader #(.ADDR_W(11), .DATA_W(16), .DEPTH(2048)) dut (
        .clock(clock), .reset(reset), .pc(pc), .instruction(instruction),
        .load_start(load_start), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .cpu_reset(cpu_reset), .load_done(load_done),
        .load_err(load_err), .word_count(word_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (load_done === 1'b1) done_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [10:0] a, output logic [15:0] d);
        pc = a;
        tick();
        d = instruction;
    endtask

    // Stream of length header followed by the words, opcode byte first.
    task automatic build(input int len, input logic [15:0] w[$]);
        logic [15:0] l16;
        l16 = 16'(len);
        tx.delete();
        tx.push_back(l16[15:8]);
        tx.push_back(l16[7:0]);
        foreach (w[i]) begin
            tx.push_back(w[i][15:8]);
            tx.push_back(w[i][7:0]);
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Sends every byte of tx; with max_gap>0 each byte is preceded by
    // 1..max_gap idle cycles.
    task automatic send(input int max_gap);
        bit ok;
        bit rdy;
        int gap;
        for (int i = 0; i < tx.size(); i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(1, max_gap)) : 0;
            byte_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                byte_data = 8'($urandom);
                tick();
            end
            byte_valid = 1'b1;
            byte_data  = tx[i];
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin
                rdy = byte_ready;
                tick();
                if (rdy) ok = 1'b1;
            end
            nchk++;
            if (!ok) begin
                nfail++;
                $display("FAIL byte_accept: byte %0d not taken within 50 cycles, required accepted", i);
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic rand_words(input int n, output logic [15:0] w[$]);
        w.delete();
        for (int i = 0; i < n; i++) w.push_back(16'($urandom));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        nchk++; if (instruction !== 16'h0000) begin nfail++; $display("FAIL rst_instr: got %h want 0000", instruction); end
        nchk++; if (cpu_reset !== 1'b0) begin nfail++; $display("FAIL rst_cpu_reset: got %b want 0", cpu_reset); end
        nchk++; if (byte_ready !== 1'b0) begin nfail++; $display("FAIL rst_byte_ready: got %b want 0", byte_ready); end
        nchk++; if (load_done !== 1'b0) begin nfail++; $display("FAIL rst_load_done: got %b want 0", load_done); end
        nchk++; if (load_err !== 1'b0) begin nfail++; $display("FAIL rst_load_err: got %b want 0", load_err); end
        nchk++; if (word_count !== 12'd0) begin nfail++; $display("FAIL rst_word_count: got %0d want 0", word_count); end
    endtask

    task automatic test_full_len();
        logic [15:0] w[$];
        logic [15:0] d;
        int d0;
        int unsigned a;
        rand_words(2048, w);
        build(2048, w);
        d0 = done_cnt;
        pulse_start();
        send(0);
        repeat (2) tick();
        foreach (w[i]) ref_mem[i] = w[i];
        nchk++; if (done_cnt !== d0 + 1) begin nfail++; $display("FAIL full_done: pulses %0d want 1", done_cnt - d0); end
        nchk++; if (word_count !== 12'd2048) begin nfail++; $display("FAIL full_wc: got %0d want 2048", word_count); end
        nchk++; if (cpu_reset !== 1'b0) begin nfail++; $display("FAIL full_cpu_reset: got %b want 0", cpu_reset); end
        for (int k = 0; k < 10; k++) begin
            a = (k == 0) ? 0 : (k == 1) ? 2047 : $urandom_range(0, 2047);
            fetch(11'(a), d);
            nchk++; if (d !== ref_mem[a]) begin nfail++; $display("FAIL full_mem[%0d]: got %h want %h", a, d, ref_mem[a]); end
        end
    endtask

    task automatic test_normal();
        logic [15:0] w[$];
        logic [15:0] d;
        int d0;
        w = '{16'h0805, 16'h1006, 16'h0000};
        build(3, w);
        d0 = done_cnt;
        // byte offered together with load_start must be dropped
        load_start = 1'b1; byte_valid = 1'b1; byte_data = 8'hAA;
        tick();
        load_start = 1'b0; byte_valid = 1'b0;
        send(0);
        nchk++; if (load_done !== 1'b1) begin nfail++; $display("FAIL norm_done_pulse: got %b want 1", load_done); end
        nchk++; if (cpu_reset !== 1'b1) begin nfail++; $display("FAIL norm_cpu_reset_done: got %b want 1", cpu_reset); end
        tick();
        nchk++; if (cpu_reset !== 1'b0) begin nfail++; $display("FAIL norm_cpu_reset_run: got %b want 0", cpu_reset); end
        nchk++; if (load_done !== 1'b0) begin nfail++; $display("FAIL norm_done_clear: got %b want 0", load_done); end
        nchk++; if (word_count !== 12'd3) begin nfail++; $display("FAIL norm_wc: got %0d want 3", word_count); end
        nchk++; if (done_cnt !== d0 + 1) begin nfail++; $display("FAIL norm_done_count: pulses %0d want 1", done_cnt - d0); end
        foreach (w[i]) ref_mem[i] = w[i];
        for (int a = 0; a < 4; a++) begin
            fetch(11'(a), d);
            nchk++; if (d !== ref_mem[a]) begin nfail++; $display("FAIL norm_mem[%0d]: got %h want %h", a, d, ref_mem[a]); end
        end
    endtask

    task automatic test_gaps();
        logic [15:0] w[$];
        logic [15:0] d;
        int d0;
        rand_words(3, w);
        build(3, w);
        d0 = done_cnt;
        pulse_start();
        send(3);
        repeat (2) tick();
        foreach (w[i]) ref_mem[i] = w[i];
        nchk++; if (word_count !== 12'd3) begin nfail++; $display("FAIL gap_wc: got %0d want 3", word_count); end
        nchk++; if (done_cnt !== d0 + 1) begin nfail++; $display("FAIL gap_done: pulses %0d want 1", done_cnt - d0); end
        for (int a = 0; a < 4; a++) begin
            fetch(11'(a), d);
            nchk++; if (d !== ref_mem[a]) begin nfail++; $display("FAIL gap_mem[%0d]: got %h want %h", a, d, ref_mem[a]); end
        end
    endtask

    task automatic test_len_zero();
        logic [15:0] w[$];
        logic [15:0] d;
        int d0;
        w.delete();
        build(0, w);
        d0 = done_cnt;
        pulse_start();
        send(0);
        repeat (2) tick();
        nchk++; if (done_cnt !== d0 + 1) begin nfail++; $display("FAIL zero_done: pulses %0d want 1", done_cnt - d0); end
        nchk++; if (word_count !== 12'd0) begin nfail++; $display("FAIL zero_wc: got %0d want 0", word_count); end
        for (int a = 0; a < 3; a++) begin
            fetch(11'(a), d);
            nchk++; if (d !== ref_mem[a]) begin nfail++; $display("FAIL zero_mem[%0d]: got %h want %h", a, d, ref_mem[a]); end
        end
    endtask

    task automatic test_len_over();
        logic [15:0] w[$];
        logic [15:0] d;
        int d0;
        int len;
        w.delete();
        for (int k = 0; k < 3; k++) begin
            len = (k == 0) ? 2049 : int'($urandom_range(2050, 65535));
            build(len, w);
            d0 = done_cnt;
            pulse_start();
            send(0);
            nchk++; if (load_err !== 1'b1) begin nfail++; $display("FAIL over_err len=%0d: got %b want 1", len, load_err); end
            nchk++; if (cpu_reset !== 1'b0) begin nfail++; $display("FAIL over_cpu_reset len=%0d: got %b want 0", len, cpu_reset); end
            nchk++; if (byte_ready !== 1'b0) begin nfail++; $display("FAIL over_ready len=%0d: got %b want 0", len, byte_ready); end
            repeat (2) tick();
            nchk++; if (done_cnt !== d0) begin nfail++; $display("FAIL over_done len=%0d: pulses %0d want 0", len, done_cnt - d0); end
            nchk++; if (word_count !== 12'd0) begin nfail++; $display("FAIL over_wc: got %0d want 0", word_count); end
            nchk++; if (load_err !== 1'b1) begin nfail++; $display("FAIL over_err_sticky: got %b want 1", load_err); end
        end
        for (int a = 0; a < 3; a++) begin
            fetch(11'(a), d);
            nchk++; if (d !== ref_mem[a]) begin nfail++; $display("FAIL over_mem[%0d]: got %h want %h", a, d, ref_mem[a]); end
        end
    endtask

    task automatic test_start_ignored();
        logic [15:0] w[$];
        logic [7:0]  all[$];
        logic [15:0] d;
        int d0;
        rand_words(3, w);
        build(3, w);
        all = tx;
        d0 = done_cnt;
        pulse_start();
        nchk++; if (load_err !== 1'b0) begin nfail++; $display("FAIL ign_err_clear: got %b want 0", load_err); end
        tx = all[0:3];
        send(0);
        pulse_start();
        tx = all[4:7];
        send(0);
        repeat (2) tick();
        foreach (w[i]) ref_mem[i] = w[i];
        nchk++; if (word_count !== 12'd3) begin nfail++; $display("FAIL ign_wc: got %0d want 3", word_count); end
        nchk++; if (done_cnt !== d0 + 1) begin nfail++; $display("FAIL ign_done: pulses %0d want 1", done_cnt - d0); end
        for (int a = 0; a < 3; a++) begin
            fetch(11'(a), d);
            nchk++; if (d !== ref_mem[a]) begin nfail++; $display("FAIL ign_mem[%0d]: got %h want %h", a, d, ref_mem[a]); end
        end
    endtask

    task automatic test_reset_midload();
        logic [15:0] w[$];
        logic [7:0]  all[$];
        logic [15:0] d;
        int d0;
        rand_words(3, w);
        build(3, w);
        all = tx;
        d0 = done_cnt;
        pulse_start();
        tx = all[0:4];
        send(0);
        #2 reset = 1'b1;
        #3 reset = 1'b0;
        ref_mem[0] = w[0];
        nchk++; if (byte_ready !== 1'b0) begin nfail++; $display("FAIL mid_ready: got %b want 0", byte_ready); end
        nchk++; if (cpu_reset !== 1'b0) begin nfail++; $display("FAIL mid_cpu_reset: got %b want 0", cpu_reset); end
        tick();
        for (int a = 0; a < 2; a++) begin
            fetch(11'(a), d);
            nchk++; if (d !== ref_mem[a]) begin nfail++; $display("FAIL mid_mem[%0d]: got %h want %h", a, d, ref_mem[a]); end
        end
        nchk++; if (done_cnt !== d0) begin nfail++; $display("FAIL mid_done: pulses %0d want 0", done_cnt - d0); end
        rand_words(3, w);
        build(3, w);
        d0 = done_cnt;
        pulse_start();
        send(2);
        repeat (2) tick();
        foreach (w[i]) ref_mem[i] = w[i];
        nchk++; if (done_cnt !== d0 + 1) begin nfail++; $display("FAIL mid_reload_done: pulses %0d want 1", done_cnt - d0); end
        for (int a = 0; a < 3; a++) begin
            fetch(11'(a), d);
            nchk++; if (d !== ref_mem[a]) begin nfail++; $display("FAIL mid_reload_mem[%0d]: got %h want %h", a, d, ref_mem[a]); end
        end
    endtask

    initial begin
        test_reset();
        test_full_len();
        test_normal();
        test_gaps();
        test_len_zero();
        test_len_over();
        test_start_ignored();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
